alu_status_reg: RTL and testbench

ALU_STATUS_REG -- requirements
Module: alu_status_reg

---
 rtl/alu_status_reg.sv | 112 +++++++++++
 tb/tb_alu_status_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_reg.sv
// 6502-style processor status register with flag update priority and an optional
// one-cycle decimal N/Z fixup state (enabled by the DEC_NZ_FIXUP_EN macro).
module alu_status_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       arith,
  input  logic [7:0] adj_result,
  input  logic [2:0] flag_cmd,
  input  logic       load_p,
  input  logic [7:0] db_in,
  input  logic       bit_op,
  input  logic       irq_ack,
  input  logic       brk,
  output logic [7:0] p_out,
  output logic       c_out,
  output logic       dec_add,
  output logic       busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, FIXUP = 1'b1} state_t;

  state_t state_r;
  logic   n_r, v_r, d_r, i_r, z_r, c_r;
  logic   alu_upd_s;
  logic   fixup_entry_s;

  // An ALU result arriving while a fixup is pending is dropped.
  assign alu_upd_s = alu_valid && (state_r == IDLE);

`ifdef DEC_NZ_FIXUP_EN
  assign fixup_entry_s = alu_upd_s && upd_nz && arith && d_r && !load_p;
  assign busy          = (state_r == FIXUP);
`else
  assign fixup_entry_s = 1'b0;
  assign busy          = 1'b0;
`endif

  // Flag and state update: sources applied lowest priority first, so later writes win.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_r     <= 1'b0;
      v_r     <= 1'b0;
      d_r     <= 1'b0;
      i_r     <= 1'b1;
      z_r     <= 1'b0;
      c_r     <= 1'b0;
      state_r <= IDLE;
    end else begin
      if (irq_ack) begin
        i_r <= 1'b1;
      end
      case (flag_cmd)
        3'd1:    c_r <= 1'b0;
        3'd2:    c_r <= 1'b1;
        3'd3:    i_r <= 1'b0;
        3'd4:    i_r <= 1'b1;
        3'd5:    d_r <= 1'b0;
        3'd6:    d_r <= 1'b1;
        3'd7:    v_r <= 1'b0;
        default: ;
      endcase
      if (bit_op) begin
        n_r <= db_in[7];
        v_r <= db_in[6];
        z_r <= (alu_result == 8'h00);
      end
      if (alu_upd_s) begin
        if (upd_c) begin
          c_r <= alu_carry;
        end
        if (upd_v) begin
          v_r <= alu_overflow;
        end
        // On fixup entry N/Z are claimed but held until the adjusted byte arrives.
        if (fixup_entry_s) begin
          n_r     <= n_r;
          z_r     <= z_r;
          state_r <= FIXUP;
        end else if (upd_nz) begin
          n_r <= alu_result[7];
          z_r <= (alu_result == 8'h00);
        end
      end
      if (state_r == FIXUP) begin
        n_r     <= adj_result[7];
        z_r     <= (adj_result == 8'h00);
        state_r <= IDLE;
      end
      if (load_p) begin
        n_r     <= db_in[7];
        v_r     <= db_in[6];
        d_r     <= db_in[3];
        i_r     <= db_in[2];
        z_r     <= db_in[1];
        c_r     <= db_in[0];
        state_r <= IDLE;
      end
    end
  end

  assign p_out   = {n_r, v_r, 1'b1, brk, d_r, i_r, z_r, c_r};
  assign c_out   = c_r;
  assign dec_add = d_r & arith;

endmodule

// File: tb/tb_alu_status_reg.sv
// Self-checking bench for alu_status_reg: per-flag priority model plus directed literals.
module tb_alu_status_reg;

  logic       clk = 1'b0;
  logic       reset, alu_valid, alu_carry, alu_overflow, upd_nz, upd_c, upd_v, arith;
  logic       load_p, bit_op, irq_ack, brk;
  logic [7:0] alu_result, adj_result, db_in;
  logic [2:0] flag_cmd;
  logic [7:0] p_out;
  logic       c_out, dec_add, busy;

  int checks = 0;
  int errors = 0;

  localparam int FN = 5, FV = 4, FD = 3, FI = 2, FZ = 1, FC = 0;

`ifdef DEC_NZ_FIXUP_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic [5:0] m;
  logic [5:0] m_nxt;
  logic [5:0] m_claim;
  logic       m_busy;
  logic       m_live = 1'b0;

  alu_status_reg dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .upd_nz(upd_nz),
    .upd_c(upd_c), .upd_v(upd_v), .arith(arith), .adj_result(adj_result),
    .flag_cmd(flag_cmd), .load_p(load_p), .db_in(db_in), .bit_op(bit_op),
    .irq_ack(irq_ack), .brk(brk), .p_out(p_out), .c_out(c_out),
    .dec_add(dec_add), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A flag takes the value of the first (highest priority) source that claims it.
  task automatic put(input int k, input logic val);
    if (!m_claim[k]) begin
      m_nxt[k]   = val;
      m_claim[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m      = 6'b000100;
      m_busy = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      logic go_fix;
      m_nxt   = m;
      m_claim = 6'b000000;
      go_fix  = 1'b0;
      if (load_p) begin
        put(FN, db_in[7]); put(FV, db_in[6]); put(FD, db_in[3]);
        put(FI, db_in[2]); put(FZ, db_in[1]); put(FC, db_in[0]);
      end
      if (m_busy) begin
        put(FN, adj_result[7]);
        put(FZ, adj_result == 8'h00);
      end
      if (alu_valid && !m_busy) begin
        if (upd_c) put(FC, alu_carry);
        if (upd_v) put(FV, alu_overflow);
        if (upd_nz) begin
          if (FIX && arith && m[FD] && !load_p) begin
            go_fix = 1'b1;
            put(FN, m[FN]);
            put(FZ, m[FZ]);
          end else begin
            put(FN, alu_result[7]);
            put(FZ, alu_result == 8'h00);
          end
        end
      end
      if (bit_op) begin
        put(FN, db_in[7]); put(FV, db_in[6]); put(FZ, alu_result == 8'h00);
      end
      case (flag_cmd)
        3'd1: put(FC, 1'b0);
        3'd2: put(FC, 1'b1);
        3'd3: put(FI, 1'b0);
        3'd4: put(FI, 1'b1);
        3'd5: put(FD, 1'b0);
        3'd6: put(FD, 1'b1);
        3'd7: put(FV, 1'b0);
        default: ;
      endcase
      if (irq_ack) put(FI, 1'b1);
      m      = m_nxt;
      m_busy = go_fix;
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_live) begin
      check("p_out", p_out, {m[FN], m[FV], 1'b1, brk, m[FD], m[FI], m[FZ], m[FC]});
      check("c_out", {7'd0, c_out}, {7'd0, m[FC]});
      check("dec_add", {7'd0, dec_add}, {7'd0, m[FD] & arith});
      check("busy", {7'd0, busy}, {7'd0, m_busy});
    end
  end

  task automatic idle();
    alu_valid = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
    alu_carry = 1'b0; alu_overflow = 1'b0; alu_result = 8'h00; adj_result = 8'h00;
    flag_cmd = 3'd0; load_p = 1'b0; db_in = 8'h00; bit_op = 1'b0; irq_ack = 1'b0;
    reset = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    idle(); load_p = 1'b1; db_in = val; cyc();
  endtask

  task automatic dec_op();
    idle(); arith = 1'b1; alu_valid = 1'b1; upd_nz = 1'b1; upd_c = 1'b1;
    alu_result = 8'h9A; adj_result = 8'h00; alu_carry = 1'b1; cyc();
  endtask

  initial begin
    idle(); arith = 1'b0; brk = 1'b0;
    // Reset must override a simultaneous load.
    reset = 1'b1; load_p = 1'b1; db_in = 8'hFF; flag_cmd = 3'd2;
    cyc(); cyc();
    check("reset_p", p_out, 8'h24);
    check("reset_c", {7'd0, c_out}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);

    idle(); flag_cmd = 3'd2; cyc();
    check("sec_p", p_out, 8'h25);
    check("sec_c", {7'd0, c_out}, 8'h01);

    idle(); alu_valid = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    alu_result = 8'h00; alu_carry = 1'b1; alu_overflow = 1'b1; cyc();
    check("alu_zero_p", p_out, 8'h67);

    idle(); load_p = 1'b1; db_in = 8'hCF; flag_cmd = 3'd1; irq_ack = 1'b1; cyc();
    check("load_wins_p", p_out, 8'hEF);

    for (int k = 1; k < 8; k++) begin
      idle(); flag_cmd = 3'(k); cyc();
    end
    idle(); cyc();
    check("flag_sweep_p", p_out, 8'hAF);

    brk = 1'b1; #1;
    check("brk_p", p_out, 8'hBF);
    arith = 1'b1; #1;
    check("dec_add_on", {7'd0, dec_add}, 8'h01);
    brk = 1'b0; arith = 1'b0;

    load(8'h8C);
    check("pre_dec_p", p_out, 8'hAC);
    dec_op();
    // Second cycle: stray ALU update, dropped while a fixup is pending.
    idle(); arith = 1'b1; alu_valid = 1'b1; upd_c = 1'b1; alu_carry = 1'b0;
`ifdef DEC_NZ_FIXUP_EN
    check("fix_hold_p", p_out, 8'hAD);
    check("fix_busy", {7'd0, busy}, 8'h01);
    cyc();
    check("fix_done_p", p_out, 8'h2F);
    check("fix_idle", {7'd0, busy}, 8'h00);
`else
    check("nofix_p", p_out, 8'hAD);
    check("nofix_busy", {7'd0, busy}, 8'h00);
    cyc();
    check("nofix_next_p", p_out, 8'hAC);
`endif
    arith = 1'b0;

    load(8'h8C);
    dec_op();
    load(8'h00);
    check("abort_p", p_out, 8'h20);
    check("abort_busy", {7'd0, busy}, 8'h00);

    load(8'h8C);
    dec_op();
    idle(); reset = 1'b1; cyc();
    check("reset_mid_p", p_out, 8'h24);
    check("reset_mid_busy", {7'd0, busy}, 8'h00);
    load(8'h00);

    idle(); bit_op = 1'b1; db_in = 8'hC0; alu_result = 8'h00; cyc();
    check("bit_p", p_out, 8'hE2);
    idle(); bit_op = 1'b1; db_in = 8'hC0; alu_valid = 1'b1; upd_nz = 1'b1;
    alu_result = 8'h01; cyc();
    check("alu_over_bit_p", p_out, 8'h60);
    idle(); irq_ack = 1'b1; flag_cmd = 3'd3; cyc();
    check("cli_over_irq_p", p_out, 8'h60);
    idle(); irq_ack = 1'b1; flag_cmd = 3'd2; cyc();
    check("irq_and_sec_p", p_out, 8'h65);

    for (int k = 0; k < 60; k++) begin
      idle();
      arith        = 1'($urandom_range(0, 1));
      brk          = 1'($urandom_range(0, 1));
      alu_valid    = 1'($urandom_range(0, 1));
      upd_nz       = 1'($urandom_range(0, 1));
      upd_c        = 1'($urandom_range(0, 1));
      upd_v        = 1'($urandom_range(0, 1));
      alu_carry    = 1'($urandom_range(0, 1));
      alu_overflow = 1'($urandom_range(0, 1));
      alu_result   = 8'($urandom_range(0, 3)) << 6;
      adj_result   = 8'($urandom_range(0, 255));
      flag_cmd     = 3'($urandom_range(0, 7));
      bit_op       = ($urandom_range(0, 3) == 0);
      irq_ack      = ($urandom_range(0, 3) == 0);
      load_p       = ($urandom_range(0, 7) == 0);
      db_in        = 8'($urandom_range(0, 255));
      cyc();
    end

    idle(); brk = 1'b0; arith = 1'b0; cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
